cu_fsm: RTL and testbench

Multicycle sequencing controller for the OTTER RISC-V core; it drives the enables that the combinational decoder cannot: PC, register-file and CSR writes, and instruction/data memory strobes. It steps each instruction through FETCH, EXEC and an optional load WRITEBACK, stalls on memory-ready handshakes, and inserts a one-cycle interrupt-entry state between instructions. The decoder consumes INT_TAKEN from this block.

---
 rtl/otter_pkg.sv | 26 ++
 rtl/intr_capture.sv | 35 +++
 rtl/cu_fsm.sv | 133 +++++++++++++
 tb/tb_cu_fsm.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/otter_pkg.sv
// Shared OTTER definitions: opcode/funct3 constants and control-unit state encoding.
package otter_pkg;

    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_SYS    = 7'b1110011;

    localparam logic [2:0] F3_CSRRW = 3'b001;
    localparam logic [2:0] F3_MRET  = 3'b000;

    typedef enum logic [2:0] {
        StInit,
        StFetch,
        StExec,
        StWb,
        StIntr
    } cu_state_t;

endpackage

// File: rtl/intr_capture.sv
// Interrupt capture: 2-flop synchronizer, rising-edge detect and sticky pending latch.
module intr_capture (
    input  logic clk,
    input  logic rst_n,
    input  logic set,
    input  logic clear,
    output logic int_pending
);

    logic sync1_q, sync2_q, sync3_q;
    logic pending_q, pending_d;
    logic edge_det;

    assign edge_det = sync2_q & ~sync3_q;

    // A new edge wins over a simultaneous clear so no request is lost.
    assign pending_d = edge_det | (pending_q & ~clear);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q   <= 1'b0;
            sync2_q   <= 1'b0;
            sync3_q   <= 1'b0;
            pending_q <= 1'b0;
        end else begin
            sync1_q   <= set;
            sync2_q   <= sync1_q;
            sync3_q   <= sync2_q;
            pending_q <= pending_d;
        end
    end

    assign int_pending = pending_q;

endmodule

// File: rtl/cu_fsm.sv
// OTTER multicycle control unit: FETCH/EXEC/WB sequencing with memory stalls.
// Define CU_FSM_INTR_EN to include interrupt capture and the INTR entry state.
module cu_fsm
    import otter_pkg::*;
(
    input  logic       CLK,
    input  logic       RST_N,
    input  logic [6:0] OPCODE,
    input  logic [2:0] FUNC3,
    input  logic       IMEM_RDY,
    input  logic       DMEM_RDY,
    input  logic       INTR,
    input  logic       MIE,
    output logic       PC_WE,
    output logic       RF_WE,
    output logic       CSR_WE,
    output logic       MEM_RDEN1,
    output logic       MEM_RDEN2,
    output logic       MEM_WE2,
    output logic       INT_TAKEN,
    output logic       CORE_RST
);

    cu_state_t state_q, state_d;
    cu_state_t retire_state;

`ifdef CU_FSM_INTR_EN
    logic int_pending;

    intr_capture u_intr_capture (
        .clk         (CLK),
        .rst_n       (RST_N),
        .set         (INTR),
        .clear       (state_q == StIntr),
        .int_pending (int_pending)
    );

    assign retire_state = (int_pending && MIE) ? StIntr : StFetch;
`else
    logic unused_intr;
    assign unused_intr  = INTR ^ MIE;
    assign retire_state = StFetch;
`endif

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= StInit;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        PC_WE     = 1'b0;
        RF_WE     = 1'b0;
        CSR_WE    = 1'b0;
        MEM_RDEN1 = 1'b0;
        MEM_RDEN2 = 1'b0;
        MEM_WE2   = 1'b0;
        INT_TAKEN = 1'b0;
        CORE_RST  = 1'b0;

        unique case (state_q)
            StInit: begin
                CORE_RST = 1'b1;
                state_d  = StFetch;
            end

            StFetch: begin
                MEM_RDEN1 = 1'b1;
                if (IMEM_RDY) begin
                    state_d = StExec;
                end
            end

            StExec: begin
                case (OPCODE)
                    OP_RTYPE, OP_ITYPE, OP_LUI, OP_AUIPC, OP_JAL, OP_JALR: begin
                        PC_WE = 1'b1;
                        RF_WE = 1'b1;
                    end
                    OP_BRANCH: begin
                        PC_WE = 1'b1;
                    end
                    OP_SYS: begin
                        PC_WE = 1'b1;
                        if (FUNC3 == F3_CSRRW) begin
                            RF_WE  = 1'b1;
                            CSR_WE = 1'b1;
                        end
                    end
                    OP_LOAD: begin
                        MEM_RDEN2 = 1'b1;
                        if (DMEM_RDY) begin
                            state_d = StWb;
                        end
                    end
                    OP_STORE: begin
                        MEM_WE2 = 1'b1;
                        PC_WE   = DMEM_RDY;
                    end
                    default: begin
                        PC_WE = 1'b1;
                    end
                endcase
                // Retire point: any EXEC cycle that advances the PC.
                if (PC_WE) begin
                    state_d = retire_state;
                end
            end

            StWb: begin
                RF_WE   = 1'b1;
                PC_WE   = 1'b1;
                state_d = retire_state;
            end

`ifdef CU_FSM_INTR_EN
            StIntr: begin
                INT_TAKEN = 1'b1;
                PC_WE     = 1'b1;
                state_d   = StFetch;
            end
`endif

            default: begin
                state_d = StInit;
            end
        endcase
    end

endmodule

// File: tb/tb_cu_fsm.sv
// Self-checking bench for cu_fsm: vector table plus hand sequences for stalls and interrupts.
module tb_cu_fsm;

    typedef struct packed {
        logic pc_we;
        logic rf_we;
        logic csr_we;
        logic rden1;
        logic rden2;
        logic we2;
        logic int_taken;
        logic core_rst;
    } outs_t;

    typedef struct {
        logic [6:0] op;
        logic [2:0] f3;
        outs_t      exec;
        string      nm;
    } vec_t;

    logic       CLK = 1'b0;
    logic       RST_N;
    logic [6:0] OPCODE;
    logic [2:0] FUNC3;
    logic       IMEM_RDY, DMEM_RDY, INTR, MIE;
    logic       PC_WE, RF_WE, CSR_WE, MEM_RDEN1, MEM_RDEN2, MEM_WE2, INT_TAKEN, CORE_RST;

    int n_pass  = 0;
    int n_total = 0;

    outs_t exp_q[$];
    string name_q[$];
    outs_t act;

    always #5 CLK = ~CLK;

    cu_fsm dut (
        .CLK       (CLK),
        .RST_N     (RST_N),
        .OPCODE    (OPCODE),
        .FUNC3     (FUNC3),
        .IMEM_RDY  (IMEM_RDY),
        .DMEM_RDY  (DMEM_RDY),
        .INTR      (INTR),
        .MIE       (MIE),
        .PC_WE     (PC_WE),
        .RF_WE     (RF_WE),
        .CSR_WE    (CSR_WE),
        .MEM_RDEN1 (MEM_RDEN1),
        .MEM_RDEN2 (MEM_RDEN2),
        .MEM_WE2   (MEM_WE2),
        .INT_TAKEN (INT_TAKEN),
        .CORE_RST  (CORE_RST)
    );

    assign act = '{PC_WE, RF_WE, CSR_WE, MEM_RDEN1, MEM_RDEN2, MEM_WE2, INT_TAKEN, CORE_RST};

    function automatic outs_t mk(input logic pc, rf, csr, r1, r2, w2, it, cr);
        outs_t o;
        o = '{pc, rf, csr, r1, r2, w2, it, cr};
        return o;
    endfunction

    localparam outs_t O_CRST  = 8'b0000_0001;
    localparam outs_t O_FETCH = 8'b0001_0000;
    localparam outs_t O_ALU   = 8'b1100_0000;
    localparam outs_t O_PC    = 8'b1000_0000;
    localparam outs_t O_CSR   = 8'b1110_0000;
    localparam outs_t O_LD    = 8'b0000_1000;
    localparam outs_t O_WB    = 8'b1100_0000;
    localparam outs_t O_STW   = 8'b0000_0100;
    localparam outs_t O_ST    = 8'b1000_0100;
    localparam outs_t O_INT   = 8'b1000_0010;

    task automatic check();
        outs_t e;
        string nm;
        e  = exp_q.pop_front();
        nm = name_q.pop_front();
        n_total++;
        if (act === e) n_pass++;
        else $display("FAIL %s: got %b want %b (pc rf csr rd1 rd2 we2 int rst)", nm, act, e);
    endtask

    // One clock cycle: queue expectation, sample mid-cycle, return just after the next edge.
    task automatic cyc(input outs_t e, input string nm);
        exp_q.push_back(e);
        name_q.push_back(nm);
        @(negedge CLK);
        check();
        @(posedge CLK);
        #1;
    endtask

    vec_t tbl[11];

    initial begin
        tbl[0]  = '{7'b0110011, 3'b000, O_ALU, "exec rtype"};
        tbl[1]  = '{7'b0010011, 3'b000, O_ALU, "exec addi"};
        tbl[2]  = '{7'b0110111, 3'b000, O_ALU, "exec lui"};
        tbl[3]  = '{7'b0010111, 3'b000, O_ALU, "exec auipc"};
        tbl[4]  = '{7'b1101111, 3'b000, O_ALU, "exec jal"};
        tbl[5]  = '{7'b1100111, 3'b000, O_ALU, "exec jalr"};
        tbl[6]  = '{7'b1100011, 3'b000, O_PC,  "exec branch"};
        tbl[7]  = '{7'b1110011, 3'b001, O_CSR, "exec csrrw"};
        tbl[8]  = '{7'b1110011, 3'b000, mk(1, 0, 0, 0, 0, 0, 0, 0), "exec mret"};
        tbl[9]  = '{7'b0100011, 3'b010, O_ST,  "exec sw nowait"};
        tbl[10] = '{7'b0001111, 3'b000, O_PC,  "exec unknown nop"};

        RST_N = 1'b0; OPCODE = 7'b0010011; FUNC3 = 3'b000;
        IMEM_RDY = 1'b1; DMEM_RDY = 1'b1; INTR = 1'b0; MIE = 1'b0;
        @(posedge CLK);
        #1;

        // Reset held, then exactly one INIT cycle, then FETCH.
        for (int i = 0; i < 3; i++) cyc(O_CRST, "reset held");
        RST_N = 1'b1;
        cyc(O_CRST, "init after reset");

        for (int i = 0; i < 11; i++) begin
            OPCODE = tbl[i].op;
            FUNC3  = tbl[i].f3;
            cyc(O_FETCH, "fetch");
            cyc(tbl[i].exec, tbl[i].nm);
        end

        // Instruction memory wait states.
        OPCODE = 7'b0010011;
        IMEM_RDY = 1'b0;
        cyc(O_FETCH, "fetch imem wait1");
        cyc(O_FETCH, "fetch imem wait2");
        IMEM_RDY = 1'b1;
        cyc(O_FETCH, "fetch imem ready");
        cyc(O_ALU, "exec after imem wait");

        // Load with two data wait cycles.
        OPCODE = 7'b0000011; DMEM_RDY = 1'b0;
        cyc(O_FETCH, "fetch lw");
        cyc(O_LD, "lw wait1");
        cyc(O_LD, "lw wait2");
        DMEM_RDY = 1'b1;
        cyc(O_LD, "lw ready");
        cyc(O_WB, "lw wb");

        // Store with one data wait cycle.
        OPCODE = 7'b0100011; DMEM_RDY = 1'b0;
        cyc(O_FETCH, "fetch sw");
        cyc(O_STW, "sw wait");
        DMEM_RDY = 1'b1;
        cyc(O_ST, "sw ready");

        // Zero-wait load takes three cycles.
        OPCODE = 7'b0000011;
        cyc(O_FETCH, "fetch lw0");
        cyc(O_LD, "lw0 exec");
        cyc(O_WB, "lw0 wb");
        OPCODE = 7'b0010011;
        cyc(O_FETCH, "fetch after lw0");

        // Asynchronous reset in the middle of EXEC.
        RST_N = 1'b0;
        #1;
        exp_q.push_back(O_CRST);
        name_q.push_back("async reset in exec");
        check();
        @(posedge CLK);
        #1;
        RST_N = 1'b1;
        cyc(O_CRST, "init after mid reset");
        cyc(O_FETCH, "fetch after mid reset");
        cyc(O_ALU, "exec after mid reset");

`ifdef CU_FSM_INTR_EN
        // Interrupt pulse during a stalled load, MIE=1: entry after WB retire.
        MIE = 1'b1; OPCODE = 7'b0000011; DMEM_RDY = 1'b0; INTR = 1'b1;
        cyc(O_FETCH, "fetch lw intr");
        INTR = 1'b0;
        cyc(O_LD, "lw intr wait1");
        cyc(O_LD, "lw intr wait2");
        DMEM_RDY = 1'b1;
        cyc(O_LD, "lw intr ready");
        cyc(O_WB, "lw intr wb");
        cyc(O_INT, "intr entry");
        OPCODE = 7'b0010011;
        cyc(O_FETCH, "fetch after intr");
        cyc(O_ALU, "exec after intr");
        cyc(O_FETCH, "pending cleared");
        cyc(O_ALU, "exec no reentry");

        // MIE=0 holds the request until a later retire with MIE=1.
        MIE = 1'b0; INTR = 1'b1;
        cyc(O_FETCH, "fetch mie0 a");
        INTR = 1'b0;
        cyc(O_ALU, "exec mie0 a");
        cyc(O_FETCH, "fetch mie0 b");
        cyc(O_ALU, "exec mie0 b pending");
        cyc(O_FETCH, "no entry while mie0");
        MIE = 1'b1;
        cyc(O_ALU, "exec mie raised");
        cyc(O_INT, "intr entry late");
        cyc(O_FETCH, "fetch after late intr");
`else
        // Interrupt logic absent: INTR held high changes nothing.
        INTR = 1'b1; MIE = 1'b1; OPCODE = 7'b0010011;
        for (int i = 0; i < 3; i++) begin
            cyc(O_FETCH, "fetch intr ignored");
            cyc(O_ALU, "exec intr ignored");
        end
        OPCODE = 7'b0000011;
        cyc(O_FETCH, "fetch lw intr ignored");
        cyc(O_LD, "lw intr ignored");
        cyc(O_WB, "wb intr ignored");
        cyc(O_FETCH, "no intr state");
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
